// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, fixed XLEN-cycle latency, sign fixup at the last step.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic [XLEN-1:0]     rem_q, rem_d;
  logic                neg_a_q, neg_a_d;
  logic                neg_b_q, neg_b_d;
  logic                dz_q, dz_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                accept;
  logic                sgn_a, sgn_b, in_neg_a, in_neg_b;
  logic [XLEN-1:0]     add_v;
  logic [XLEN:0]       sum_v;
  logic [2*XLEN-1:0]   prod_nx, prod_fix;
  logic [XLEN:0]       rsh, diff;
  logic                qbit;
  logic [XLEN-1:0]     rem_nx, quo_nx, rem_fix, quo_fix, final_val;

  // Next-state, datapath iteration and sign fixup
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    dz_d     = dz_q;
    result_d = result_q;

    sgn_a    = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    sgn_b    = sgn_a && (funct3 != 3'b010);
    in_neg_a = sgn_a & srcA[XLEN-1];
    in_neg_b = sgn_b & srcB[XLEN-1];

    // Multiply: add into the upper half, then shift the whole product right.
    add_v   = b_q[0] ? a_q : {XLEN{1'b0}};
    sum_v   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, add_v};
    prod_nx = {sum_v, prod_q[XLEN-1:1]};

    // Divide: a_q shifts the dividend out and the quotient bits in.
    rsh    = {rem_q, a_q[XLEN-1]};
    diff   = rsh - {1'b0, b_q};
    qbit   = ~diff[XLEN];
    rem_nx = qbit ? diff[XLEN-1:0] : rsh[XLEN-1:0];
    quo_nx = {a_q[XLEN-2:0], qbit};

    prod_fix = (neg_a_q ^ neg_b_q) ? -prod_nx : prod_nx;
    quo_fix  = ((neg_a_q ^ neg_b_q) && !dz_q) ? -quo_nx : quo_nx;
    rem_fix  = neg_a_q ? -rem_nx : rem_nx;

    case (op_q)
      3'b000:                 final_val = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_val = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_val = quo_fix;
      3'b110, 3'b111:         final_val = rem_fix;
      default:                final_val = {XLEN{1'b0}};
    endcase

    accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    if (accept) begin
      state_d = S_CALC;
      count_d = {CW{1'b0}};
      op_d    = funct3;
      a_d     = in_neg_a ? -srcA : srcA;
      b_d     = in_neg_b ? -srcB : srcB;
      neg_a_d = in_neg_a;
      neg_b_d = in_neg_b;
      dz_d    = (srcB == {XLEN{1'b0}});
      prod_d  = {(2*XLEN){1'b0}};
      rem_d   = {XLEN{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_CALC: begin
          count_d = count_q + CNT_ONE;
          if (op_q[2]) begin
            a_d   = quo_nx;
            rem_d = rem_nx;
          end else begin
            prod_d = prod_nx;
            b_d    = {1'b0, b_q[XLEN-1:1]};
          end
          if (count_q == CNT_LAST) begin
            state_d  = S_DONE;
            result_d = final_val;
          end else begin
            state_d = S_CALC;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_CALC);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      count_q  <= {CW{1'b0}};
      op_q     <= 3'b000;
      a_q      <= {XLEN{1'b0}};
      b_q      <= {XLEN{1'b0}};
      prod_q   <= {(2*XLEN){1'b0}};
      rem_q    <= {XLEN{1'b0}};
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= {XLEN{1'b0}};
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: arithmetic vectors, latency,
// start handling during CALC/DONE, and asynchronous reset mid-operation.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] srcA, srcB;
  logic        busy, done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  mul_div_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .srcA   (srcA),
    .srcB   (srcB),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (done !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int e;
    start = 1'b1; funct3 = f; srcA = a; srcB = b;
    @(posedge clk); #1;
    start = 1'b0; funct3 = 3'($urandom); srcA = $urandom; srcB = $urandom;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_done(e);
    chk({tag, "_lat"}, 32'(e), 32'd32);
    chk({tag, "_res"}, result, exp);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int  e;
    logic saw;
    reset = 1'b0; start = 1'b0; funct3 = 3'b000; srcA = 32'd0; srcB = 32'd0;
    #2;
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_done",   {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    run_op("mul_7_m3",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB);
    run_op("mulhu_max",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("mulh_min",     3'b001, 32'h80000000, 32'h80000000, 32'h40000000);
    run_op("mulhsu_m1",    3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("div_m7_2",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
    run_op("rem_m7_2",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
    run_op("divu_100_7",   3'b101, 32'd100,      32'd7,        32'd14);
    run_op("remu_100_7",   3'b111, 32'd100,      32'd7,        32'd2);
    run_op("div_5_0",      3'b100, 32'd5,        32'd0,        32'hFFFFFFFF);
    run_op("divu_5_0",     3'b101, 32'd5,        32'd0,        32'hFFFFFFFF);
    run_op("div_m5_0",     3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF);
    run_op("rem_m5_0",     3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB);
    run_op("div_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_op("rem_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);
    run_op("mul_shift",    3'b000, 32'h12345678, 32'h00000010, 32'h23456780);

    // start pulsed on the 10th iteration edge must be ignored
    start = 1'b1; funct3 = 3'b101; srcA = 32'd100; srcB = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    start = 1'b1; funct3 = 3'b000; srcA = 32'd3; srcB = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(e);
    chk("midstart_lat", 32'(e), 32'd22);
    chk("midstart_res", result, 32'd14);
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw = 1'b1;
    end
    chk("midstart_single_done", {31'd0, saw}, 32'd0);

    // start held through DONE launches a second op; result held until its done
    start = 1'b1; funct3 = 3'b011; srcA = 32'hFFFFFFFF; srcB = 32'hFFFFFFFF;
    @(posedge clk); #1;
    funct3 = 3'b101; srcA = 32'd100; srcB = 32'd7;
    wait_done(e);
    chk("b2b_lat1", 32'(e), 32'd32);
    chk("b2b_res1", result, 32'hFFFFFFFE);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy2", {31'd0, busy}, 32'd1);
    chk("b2b_done2", {31'd0, done}, 32'd0);
    repeat (15) begin @(posedge clk); #1; end
    chk("b2b_hold", result, 32'hFFFFFFFE);
    wait_done(e);
    chk("b2b_lat2", 32'(e), 32'd17);
    chk("b2b_res2", result, 32'd14);
    @(posedge clk); #1;

    // asynchronous reset in the middle of CALC
    start = 1'b1; funct3 = 3'b000; srcA = 32'd7; srcB = 32'hFFFFFFFD;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    chk("arst_busy",   {31'd0, busy}, 32'd0);
    chk("arst_done",   {31'd0, done}, 32'd0);
    chk("arst_result", result, 32'd0);
    @(negedge clk); reset = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) saw = 1'b1;
    end
    chk("arst_idle_after", {31'd0, saw}, 32'd0);
    run_op("post_rst_mul", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative RV32M multiply/divide unit sitting directly downstream of the ALU source-B mux. It consumes `srcA` (register-file RD1) and `srcB` (mux output), and executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over a fixed multi-cycle latency. Control holds the datapath while `busy` is high. The registered `result` feeds the writeback mux alongside the ALU result.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; iteration count equals `XLEN`.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `funct3`  in  3  M-ext op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `srcA`  in  XLEN  operand A (multiplicand/dividend).
- `srcB`  in  XLEN  operand B (multiplier/divisor), from ALU source mux.
- `busy`  out  1  high while iterating.
- `done`  out  1  one-cycle pulse when `result` becomes valid.
- `result`  out  XLEN  registered result, held until next accepted start.

## Operation
- States:
  - IDLE: `start`=1 → CALC.
  - CALC: at count=XLEN-1 → DONE.
  - DONE: `start`=1 → CALC; otherwise → IDLE.
- Accept: at the rising edge with `start`=1 in IDLE/DONE:
  - capture `funct3`;
  - capture operand magnitudes (abs per signedness) and result-sign flags;
  - clear count and partial product/remainder.
- `srcA`/`srcB`/`funct3` may change after acceptance without effect.
- Signedness:
  - MUL, MULH, DIV, REM: both signed.
  - MULHSU: A signed, B unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- Multiply: radix-2 shift-add on magnitudes into a 2·XLEN product, one bit per cycle. Negate the 64-bit product if the sign flags differ.
  - MUL returns product[31:0].
  - MULH* return product[63:32].
- Divide: restoring, one quotient bit per cycle on magnitudes.
  - Quotient negated if signs differ; remainder takes the dividend's sign.
- Divide by zero:
  - quotient = 0xFFFFFFFF (quotient sign fixup suppressed);
  - remainder = dividend.
- Overflow (DIV 0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0. Falls out of magnitude arithmetic; no special path.
- `start` in CALC is ignored (no queueing).
- No early-out: latency is data-independent.

## Timing
- Reset (async assert, sync release): state IDLE, `busy`=0, `done`=0, `result`=0, count=0, all internal datapath registers 0.
- Reset asserted mid-CALC aborts immediately; no `done` is produced.
- Edge E0 accepts `start`. `busy`=1 from after E0 until after E32.
- Iterations occur on edges E1..E32.
- At E32: `result` is loaded with the sign-fixed value and state → DONE.
  - `done`=1 and `busy`=0 for the cycle after E32.
  - Latency: 32 cycles from accept edge to `done`.
- Back-to-back: `start`=1 during DONE re-enters CALC at E33. `result` keeps its old value until the new E32.
- `busy` and `done` are never high simultaneously. `busy`=0 in IDLE and DONE.

## Test plan
- MUL srcA=7, srcB=0xFFFFFFFD (−3) → `done` exactly 32 cycles after accept, `result`=0xFFFFFFEB. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF(−1)×0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Divide by zero:
  - DIV 5/0 and DIVU 5/0 → 0xFFFFFFFF.
  - REM −5/0 → 0xFFFFFFFB.
  - Overflow: DIV 0x80000000/−1 → 0x80000000; REM of the same → 0.
- Robustness:
  - `start` pulsed mid-CALC → ignored; single `done` with original result.
  - Operands changed after accept → no effect.
  - `start` held through DONE → second op starts; `result` unchanged until its `done`.
- `reset` low mid-CALC (cycle 10) → `busy`/`done`/`result` = 0 immediately. After release: IDLE; no `done` until a new start.
